// File: rtl/dp_pipe_elastic.sv
// Elastic pipeline register chain: STAGES stages, each with a main and a skid
// register, registered ready, per-stage flush that squashes held words.
module dp_pipe_elastic #(
  parameter int          WIDTH      = 32,
  parameter int          STAGES     = 3,
  parameter logic [31:0] INIT_VALUE = 32'h0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_data,
  input  logic [STAGES-1:0]                  flush,
  output logic [$clog2(2*STAGES+1)-1:0]      count
);

  localparam int               CW     = $clog2(2*STAGES+1);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VALUE);

  // Handshake: a word moves across a boundary on a clock edge where the sender
  // has valid=1 and the receiver has ready=1; ready of a stage is ~skid_v, so it
  // never depends combinationally on anything downstream.

  logic [STAGES-1:0]            main_v_q, main_v_d;
  logic [STAGES-1:0]            skid_v_q, skid_v_d;
  logic [STAGES-1:0][WIDTH-1:0] main_d_q, main_d_d;
  logic [STAGES-1:0][WIDTH-1:0] skid_d_q, skid_d_d;

  logic [STAGES-1:0]            up_valid;
  logic [STAGES-1:0][WIDTH-1:0] up_data;
  logic [STAGES-1:0]            dn_ready;
  logic [STAGES-1:0]            accept;
  logic [STAGES-1:0]            drain;
  logic [CW-1:0]                count_sum;

  always_comb begin
    up_valid    = '0;
    up_data     = '0;
    dn_ready    = '0;
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < STAGES; i++) begin
      up_valid[i] = main_v_q[i-1];
      up_data[i]  = main_d_q[i-1];
    end
    for (int i = 0; i < STAGES - 1; i++) begin
      dn_ready[i] = ~skid_v_q[i+1];
    end
    dn_ready[STAGES-1] = out_ready;
    accept = up_valid & ~skid_v_q;
    drain  = main_v_q & dn_ready;
  end

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    for (int i = 0; i < STAGES; i++) begin
      if (!main_v_q[i] || drain[i]) begin
        // Skid is older than anything upstream, so it refills main first.
        if (skid_v_q[i]) begin
          main_v_d[i] = 1'b1;
          main_d_d[i] = skid_d_q[i];
          skid_v_d[i] = 1'b0;
        end else begin
          main_v_d[i] = accept[i];
          if (accept[i]) begin
            main_d_d[i] = up_data[i];
          end
        end
      end else if (accept[i]) begin
        skid_v_d[i] = 1'b1;
        skid_d_d[i] = up_data[i];
      end
      // Flush drops the stage contents but the upstream handshake still completes.
      if (flush[i]) begin
        main_v_d[i] = 1'b0;
        skid_v_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v_q <= '0;
      skid_v_q <= '0;
      main_d_q <= {STAGES{INIT_W}};
      skid_d_q <= {STAGES{INIT_W}};
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
    end
  end

  always_comb begin
    count_sum = '0;
    for (int i = 0; i < STAGES; i++) begin
      count_sum = count_sum + CW'(main_v_q[i]) + CW'(skid_v_q[i]);
    end
  end

  assign in_ready  = ~skid_v_q[0];
  assign out_valid = main_v_q[STAGES-1];
  assign out_data  = main_d_q[STAGES-1];
  assign count     = count_sum;

endmodule

// File: tb/tb_dp_pipe_elastic.sv
// Directed bench for dp_pipe_elastic (WIDTH=32, STAGES=3): reset, streaming,
// backpressure, selective flush, flush on accept, reset mid-operation.
module tb_dp_pipe_elastic;

  localparam int W = 32;
  localparam int S = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [S-1:0]  flush;
  logic [2:0]    count;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  dp_pipe_elastic #(.WIDTH(W), .STAGES(S), .INIT_VALUE(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every word consumed downstream must be the next expected one.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", {31'b0, out_valid}, 32'h0);
      end else begin
        check("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  // Offer nxt while below limit for n cycles; nxt advances on each handshake.
  task automatic drive(input int n, input logic [W-1:0] limit, inout logic [W-1:0] nxt);
    logic acc;
    for (int c = 0; c < n; c++) begin
      in_valid = (nxt <= limit);
      in_data  = nxt;
      acc      = in_valid && in_ready;
      tick();
      if (acc) nxt = nxt + 1;
    end
    in_valid = 1'b0;
  endtask

  logic [W-1:0] nxt;

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA_AAAA;
    out_ready = 1'b0; flush = '0;
    tick(); tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_count",     {29'b0, count},     32'h0);
    check("rst_in_ready",  {31'b0, in_ready},  32'h1);
    check("rst_out_data",  out_data,           32'h0);

    // Streaming 0x1..0x8, first output after the third edge.
    rst = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) exp_q.push_back(W'(k));
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = W'(k);
      tick();
      check("stream_in_ready",  {31'b0, in_ready},  32'h1);
      check("stream_out_valid", {31'b0, out_valid}, (k >= 3) ? 32'h1 : 32'h0);
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("stream_drained", exp_q.size(), 32'h0);
    check("stream_count",   {29'b0, count}, 32'h0);

    // Backpressure: exactly six words fit.
    out_ready = 1'b0; nxt = 32'h10;
    drive(12, 32'h1F, nxt);
    check("bp_accepted", nxt, 32'h16);
    check("bp_count",    {29'b0, count},    32'h6);
    check("bp_in_ready", {31'b0, in_ready}, 32'h0);
    for (int k = 32'h10; k <= 32'h1F; k++) exp_q.push_back(W'(k));
    out_ready = 1'b1;
    drive(16, 32'h1F, nxt);
    check("bp_all_sent", nxt, 32'h20);
    check("bp_no_gap",   exp_q.size(), 32'h0);
    check("bp_count_end", {29'b0, count}, 32'h0);

    // Selective flush of stages 0 and 1 while fully stalled.
    out_ready = 1'b0; nxt = 32'h10;
    drive(12, 32'h15, nxt);
    check("sf_count_full", {29'b0, count}, 32'h6);
    flush = 3'b011;
    tick();
    flush = '0;
    check("sf_count",    {29'b0, count},    32'h2);
    check("sf_in_ready", {31'b0, in_ready}, 32'h1);
    exp_q.push_back(32'h10); exp_q.push_back(32'h11);
    exp_q.push_back(32'h40); exp_q.push_back(32'h41);
    out_ready = 1'b1; nxt = 32'h40;
    drive(8, 32'h41, nxt);
    check("sf_drained", exp_q.size(), 32'h0);
    check("sf_count_end", {29'b0, count}, 32'h0);

    // Flush on accept: 0x55 vanishes, 0x56 follows normally.
    check("fa_in_ready", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b1; in_data = 32'h55; flush = 3'b001;
    tick();
    flush = '0;
    check("fa_count", {29'b0, count}, 32'h0);
    exp_q.push_back(32'h56);
    in_data = 32'h56;
    tick();
    in_valid = 1'b0;
    check("fa_count_next", {29'b0, count}, 32'h1);
    repeat (4) tick();
    check("fa_drained", exp_q.size(), 32'h0);

    // Reset with four words held; none may appear afterwards.
    out_ready = 1'b0; nxt = 32'h60;
    drive(4, 32'h63, nxt);
    check("rm_count_held", {29'b0, count}, 32'h4);
    rst = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b1;
    check("rm_count",     {29'b0, count},     32'h0);
    check("rm_out_valid", {31'b0, out_valid}, 32'h0);
    check("rm_in_ready",  {31'b0, in_ready},  32'h1);
    for (int c = 0; c < 6; c++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    exp_q.push_back(32'h70);
    nxt = 32'h70;
    drive(1, 32'h70, nxt);
    repeat (4) tick();
    check("rm_after_word", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
